// File: rtl/vrf_write_pkg.sv
// Shared types and field widths for the VRF write-request path.
package vrf_write_pkg;

  localparam int VD_W       = 5;
  localparam int OFFSET_W   = 8;
  localparam int INST_IDX_W = 3;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_MASK_W = REQ_DATA_W / 8;

  typedef struct packed {
    logic [VD_W-1:0]       vd;
    logic [OFFSET_W-1:0]   offset;
    logic [REQ_MASK_W-1:0] mask;
    logic [REQ_DATA_W-1:0] data;
    logic                  last;
    logic [INST_IDX_W-1:0] instructionIndex;
  } vrf_write_req_t;

endpackage

// File: rtl/vrf_pending_counter_bank.sv
// Per-instruction occupancy counters; a bit of instructionPending stays set
// while any write of that instruction is still inside the coalescer.
module vrf_pending_counter_bank
  import vrf_write_pkg::*;
#(
  parameter int NUM = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc,
  input  logic [INST_IDX_W-1:0] incIdx,
  input  logic                  dec,
  input  logic [INST_IDX_W-1:0] decIdx,
  output logic [NUM-1:0]        instructionPending
);

  logic [1:0] count [NUM];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) count[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        case ({inc && (incIdx == INST_IDX_W'(i)), dec && (decIdx == INST_IDX_W'(i))})
          2'b10:   if (count[i] != 2'd3) count[i] <= count[i] + 2'd1;
          2'b01:   if (count[i] != 2'd0) count[i] <= count[i] - 2'd1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM; i++) instructionPending[i] = (count[i] != 2'd0);
  end

endmodule

// File: rtl/vrf_write_coalescer.sv
// Merges consecutive partial writes to the same VRF row into one byte-masked
// write: a single hold entry collects merges, an out register feeds the bank.
module vrf_write_coalescer
  import vrf_write_pkg::*;
#(
  parameter int TIMEOUT = 4,
  parameter int DATA_W  = REQ_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  enq_ready,
  input  logic                  enq_valid,
  input  logic [VD_W-1:0]       enq_bits_vd,
  input  logic [OFFSET_W-1:0]   enq_bits_offset,
  input  logic [DATA_W/8-1:0]   enq_bits_mask,
  input  logic [DATA_W-1:0]     enq_bits_data,
  input  logic                  enq_bits_last,
  input  logic [INST_IDX_W-1:0] enq_bits_instructionIndex,
  input  logic                  flush,
  input  logic                  vrfWrite_ready,
  output logic                  vrfWrite_valid,
  output logic [VD_W-1:0]       vrfWrite_bits_vd,
  output logic [OFFSET_W-1:0]   vrfWrite_bits_offset,
  output logic [DATA_W/8-1:0]   vrfWrite_bits_mask,
  output logic [DATA_W-1:0]     vrfWrite_bits_data,
  output logic [INST_IDX_W-1:0] vrfWrite_bits_instructionIndex,
  output logic [7:0]            instructionPending
);

  localparam int TIMER_W = 4;

  function automatic logic [REQ_DATA_W-1:0] mergeBytes(
    input logic [REQ_DATA_W-1:0] oldData,
    input logic [REQ_DATA_W-1:0] newData,
    input logic [REQ_MASK_W-1:0] newMask
  );
    logic [REQ_DATA_W-1:0] r;
    for (int i = 0; i < REQ_MASK_W; i++)
      r[8*i +: 8] = newMask[i] ? newData[8*i +: 8] : oldData[8*i +: 8];
    return r;
  endfunction

  vrf_write_req_t        enqReq, holdReq;
  logic                  holdValid, outValid;
  logic [TIMER_W-1:0]    timer;
  logic [VD_W-1:0]       outVd;
  logic [OFFSET_W-1:0]   outOffset;
  logic [REQ_MASK_W-1:0] outMask;
  logic [REQ_DATA_W-1:0] outData;
  logic [INST_IDX_W-1:0] outIdx;
  logic outFree, match, flushHold, accept, mergeNow, loadNow, outFire;

  assign enqReq = '{vd: enq_bits_vd, offset: enq_bits_offset, mask: enq_bits_mask,
                    data: enq_bits_data, last: enq_bits_last,
                    instructionIndex: enq_bits_instructionIndex};

  assign outFree   = !outValid || vrfWrite_ready;
  assign match     = holdValid && !holdReq.last && (enqReq.vd == holdReq.vd) &&
                     (enqReq.offset == holdReq.offset) &&
                     (enqReq.instructionIndex == holdReq.instructionIndex);
  assign flushHold = holdValid && outFree &&
                     (holdReq.last || (timer == TIMER_W'(TIMEOUT)) || flush ||
                      (enq_valid && !match));
  assign enq_ready = !holdValid || match || outFree;
  assign accept    = enq_valid && enq_ready;
  // A matching request that arrives while the entry is leaving starts a fresh entry.
  assign mergeNow  = accept && match && !flushHold;
  assign loadNow   = accept && !mergeNow;
  assign outFire   = outValid && vrfWrite_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      holdValid <= 1'b0;
      outValid  <= 1'b0;
      timer     <= '0;
    end else begin
      if (loadNow) begin
        holdValid <= 1'b1;
        timer     <= '0;
      end else if (mergeNow) begin
        timer     <= '0;
      end else if (flushHold) begin
        holdValid <= 1'b0;
        timer     <= '0;
      end else if (holdValid && (timer != TIMER_W'(TIMEOUT))) begin
        timer     <= timer + 1'b1;
      end
      if (flushHold)    outValid <= 1'b1;
      else if (outFire) outValid <= 1'b0;
    end
  end

  // Payload registers carry no reset; the valid bits above qualify them.
  always_ff @(posedge clock) begin
    if (loadNow) begin
      holdReq <= enqReq;
    end else if (mergeNow) begin
      holdReq.data <= mergeBytes(holdReq.data, enqReq.data, enqReq.mask);
      holdReq.mask <= holdReq.mask | enqReq.mask;
      holdReq.last <= holdReq.last | enqReq.last;
    end
    if (flushHold) begin
      outVd     <= holdReq.vd;
      outOffset <= holdReq.offset;
      outMask   <= holdReq.mask;
      outData   <= holdReq.data;
      outIdx    <= holdReq.instructionIndex;
    end
  end

  assign vrfWrite_valid                 = outValid;
  assign vrfWrite_bits_vd               = outVd;
  assign vrfWrite_bits_offset           = outOffset;
  assign vrfWrite_bits_mask             = outMask;
  assign vrfWrite_bits_data             = outData;
  assign vrfWrite_bits_instructionIndex = outIdx;

  vrf_pending_counter_bank #(.NUM(8)) uPending (
    .clock              (clock),
    .reset              (reset),
    .inc                (loadNow),
    .incIdx             (enqReq.instructionIndex),
    .dec                (outFire),
    .decIdx             (outIdx),
    .instructionPending (instructionPending)
  );

endmodule

// File: tb/tb_vrf_write_coalescer.sv
// Scoreboard bench for vrf_write_coalescer with directed merge, timeout,
// back-pressure and reset scenarios.
module tb_vrf_write_coalescer;

  logic clock = 1'b0;
  logic reset;
  logic enq_ready, enq_valid, enq_bits_last, flush;
  logic [4:0] enq_bits_vd;
  logic [7:0] enq_bits_offset;
  logic [3:0] enq_bits_mask;
  logic [31:0] enq_bits_data;
  logic [2:0] enq_bits_instructionIndex;
  logic vrfWrite_ready, vrfWrite_valid;
  logic [4:0] vrfWrite_bits_vd;
  logic [7:0] vrfWrite_bits_offset;
  logic [3:0] vrfWrite_bits_mask;
  logic [31:0] vrfWrite_bits_data;
  logic [2:0] vrfWrite_bits_instructionIndex;
  logic [7:0] instructionPending;

  vrf_write_coalescer #(.TIMEOUT(4), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .enq_ready(enq_ready), .enq_valid(enq_valid),
    .enq_bits_vd(enq_bits_vd), .enq_bits_offset(enq_bits_offset),
    .enq_bits_mask(enq_bits_mask), .enq_bits_data(enq_bits_data),
    .enq_bits_last(enq_bits_last), .enq_bits_instructionIndex(enq_bits_instructionIndex),
    .flush(flush), .vrfWrite_ready(vrfWrite_ready), .vrfWrite_valid(vrfWrite_valid),
    .vrfWrite_bits_vd(vrfWrite_bits_vd), .vrfWrite_bits_offset(vrfWrite_bits_offset),
    .vrfWrite_bits_mask(vrfWrite_bits_mask), .vrfWrite_bits_data(vrfWrite_bits_data),
    .vrfWrite_bits_instructionIndex(vrfWrite_bits_instructionIndex),
    .instructionPending(instructionPending)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] vd; logic [7:0] off; logic [3:0] mask; logic [31:0] data; logic [2:0] idx;
  } exp_t;

  exp_t expQ[$];
  int   popCyc[$];
  int   cyc = 0;
  int   popCount = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every bank handshake is matched against the oldest expected write.
  always @(negedge clock) begin
    if (vrfWrite_valid && vrfWrite_ready) begin
      exp_t got;
      got = '{vrfWrite_bits_vd, vrfWrite_bits_offset, vrfWrite_bits_mask,
              vrfWrite_bits_data, vrfWrite_bits_instructionIndex};
      checks++;
      popCount++;
      popCyc.push_back(cyc);
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL vrfWrite_unexpected got=%h required=none", got);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL vrfWrite_payload got=%h required=%h", got, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic expect_write(input logic [4:0] vd, input logic [7:0] off,
                              input logic [3:0] m, input logic [31:0] d, input logic [2:0] idx);
    exp_t e;
    e = '{vd, off, m, d, idx};
    expQ.push_back(e);
  endtask

  // Called just after a rising edge; returns the cycle in which the request was accepted.
  task automatic sendReq(input logic [4:0] vd, input logic [7:0] off, input logic [3:0] m,
                         input logic [31:0] d, input logic last, input logic [2:0] idx,
                         output int acc);
    enq_valid = 1'b1; enq_bits_vd = vd; enq_bits_offset = off; enq_bits_mask = m;
    enq_bits_data = d; enq_bits_last = last; enq_bits_instructionIndex = idx;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (enq_ready) begin acc = cyc; break; end
      @(posedge clock); #1;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL enq_accept_timeout got=stalled required=accepted");
    end
    @(posedge clock); #1;
    enq_valid = 1'b0;
  endtask

  task automatic waitPops(input int target);
    for (int k = 0; k < 300; k++) begin
      if (popCount >= target) break;
      @(posedge clock);
    end
    #1;
    if (popCount < target) begin
      checks++; errors++;
      $display("FAIL pop_timeout got=%0d required=%0d", popCount, target);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "bank writes never arrived");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int a0, a1;
    reset = 1'b1; enq_valid = 1'b0; flush = 1'b0; vrfWrite_ready = 1'b1;
    enq_bits_vd = '0; enq_bits_offset = '0; enq_bits_mask = '0; enq_bits_data = '0;
    enq_bits_last = 1'b0; enq_bits_instructionIndex = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_valid", int'(vrfWrite_valid), 0);
    chk("reset_pending", int'(instructionPending), 0);
    chk("reset_enq_ready", int'(enq_ready), 1);
    @(posedge clock); #1;

    // Merge of two halves into one full row.
    expect_write(5'd3, 8'h10, 4'hF, 32'hDDCCBBAA, 3'd1);
    sendReq(5'd3, 8'h10, 4'b0011, 32'h0000BBAA, 1'b0, 3'd1, a0);
    sendReq(5'd3, 8'h10, 4'b1100, 32'hDDCC0000, 1'b1, 3'd1, a1);
    chk("merge_pending_held", int'(instructionPending), 8'h02);
    waitPops(1);
    chk("merge_latency", popCyc[0] - a1, 2);
    idle(1);
    chk("merge_pending_clear", int'(instructionPending), 0);

    // Overlapping byte overwritten by the later request.
    expect_write(5'd3, 8'h10, 4'hF, 32'h112233EE, 3'd2);
    sendReq(5'd3, 8'h10, 4'b1111, 32'h11223344, 1'b0, 3'd2, a0);
    sendReq(5'd3, 8'h10, 4'b0001, 32'h000000EE, 1'b1, 3'd2, a1);
    waitPops(2);
    chk("overlap_latency", popCyc[1] - a1, 2);
    idle(2);

    // Key change: no merge, order kept, second leaves on timeout.
    expect_write(5'd2, 8'h00, 4'hF, 32'hA0A0A0A0, 3'd3);
    expect_write(5'd2, 8'h01, 4'hF, 32'hB1B1B1B1, 3'd3);
    sendReq(5'd2, 8'h00, 4'hF, 32'hA0A0A0A0, 1'b0, 3'd3, a0);
    sendReq(5'd2, 8'h01, 4'hF, 32'hB1B1B1B1, 1'b0, 3'd3, a1);
    waitPops(4);
    chk("keychange_first_latency", popCyc[2] - a1, 1);
    chk("keychange_second_latency", popCyc[3] - a1, 6);
    idle(2);

    // Isolated write: timeout, then explicit flush.
    expect_write(5'd9, 8'h20, 4'b0101, 32'h00550066, 3'd0);
    sendReq(5'd9, 8'h20, 4'b0101, 32'h00550066, 1'b0, 3'd0, a0);
    waitPops(5);
    chk("timeout_latency", popCyc[4] - a0, 6);
    idle(2);
    expect_write(5'd9, 8'h21, 4'hF, 32'hCAFEF00D, 3'd0);
    sendReq(5'd9, 8'h21, 4'hF, 32'hCAFEF00D, 1'b0, 3'd0, a0);
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    waitPops(6);
    chk("flush_latency", popCyc[5] - a0, 2);
    idle(2);

    // Back-pressure: out and hold full, non-matching stalls, matching merges.
    vrfWrite_ready = 1'b0;
    expect_write(5'd5, 8'h00, 4'hF, 32'h11111111, 3'd4);
    expect_write(5'd5, 8'h01, 4'hF, 32'hAAAA5566, 3'd5);
    sendReq(5'd5, 8'h00, 4'hF, 32'h11111111, 1'b0, 3'd4, a0);
    sendReq(5'd5, 8'h01, 4'b0011, 32'h00005566, 1'b0, 3'd5, a1);
    idle(6);
    enq_valid = 1'b1; enq_bits_vd = 5'd6; enq_bits_offset = 8'h00; enq_bits_mask = 4'hF;
    enq_bits_data = 32'h66666666; enq_bits_last = 1'b0; enq_bits_instructionIndex = 3'd6;
    @(negedge clock);
    chk("bp_nonmatch_stalled", int'(enq_ready), 0);
    chk("bp_pending", int'(instructionPending), 8'h30);
    @(posedge clock); #1 enq_valid = 1'b0;
    sendReq(5'd5, 8'h01, 4'b1100, 32'hAAAA0000, 1'b0, 3'd5, a0);
    chk("bp_valid_held", int'(vrfWrite_valid), 1);
    vrfWrite_ready = 1'b1;
    waitPops(8);
    idle(2);
    chk("bp_pending_drained", int'(instructionPending), 0);

    // Reset mid-operation discards everything held.
    vrfWrite_ready = 1'b0;
    sendReq(5'd7, 8'h02, 4'hF, 32'hDEADBEEF, 1'b0, 3'd6, a0);
    sendReq(5'd7, 8'h03, 4'hF, 32'hFEEDFACE, 1'b0, 3'd7, a1);
    chk("rst_pending_before", int'(instructionPending), 8'hC0);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", int'(vrfWrite_valid), 0);
    chk("rst_pending", int'(instructionPending), 0);
    chk("rst_enq_ready", int'(enq_ready), 1);
    vrfWrite_ready = 1'b1;
    idle(20);

    chk("total_writes", popCount, 8);
    chk("scoreboard_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vrf_write_coalescer.md
Name: vrf_write_coalescer

Overview:
- Sits directly downstream of lane stage 3 and consumes its VRF write-request stream (vd, offset, mask, data, last, instructionIndex).
- Merges consecutive partial writes to the same VRF row into one byte-masked write, which cuts VRF bank write-port pressure.
- Issues the merged writes to the VRF bank port through a registered valid/ready interface.
- Reports, per instruction index, whether any of that instruction's writes are still inside the block.

Parameters:
TIMEOUT, 4, idle cycles a held entry waits for a merge partner before being forced out (range 1..15)
DATA_W, 32, write data width; mask width is DATA_W/8

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
enq_ready  out  1  block can accept a request this cycle
enq_valid  in  1  request valid
enq_bits_vd  in  5  destination register
enq_bits_offset  in  8  row offset within the register group
enq_bits_mask  in  DATA_W/8  byte enables
enq_bits_data  in  DATA_W  write data
enq_bits_last  in  1  last write for this row; forces flush after merge
enq_bits_instructionIndex  in  3  owning instruction
flush  in  1  drain request; forces the held entry out
vrfWrite_ready  in  1  VRF bank accepts the write
vrfWrite_valid  out  1  merged write valid
vrfWrite_bits_vd  out  5  merged write destination register
vrfWrite_bits_offset  out  8  merged write row offset
vrfWrite_bits_mask  out  DATA_W/8  merged write byte enables
vrfWrite_bits_data  out  DATA_W  merged write data
vrfWrite_bits_instructionIndex  out  3  merged write owning instruction
instructionPending  out  8  bit i set while instruction i has entries in hold or out

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous, active-high (reset).
- State:
  - Hold entry: hold_valid, key {vd, offset, instructionIndex}, mask, data, last, idle timer.
  - Out register: out_valid plus payload.
  - Eight 2-bit pending counters, one per instruction index.
- Reset values: hold_valid=0, out_valid=0, timer=0, all counters 0. Hence vrfWrite_valid=0, instructionPending=0, enq_ready=1 in the first cycle after reset. Reset mid-operation discards all held data without issuing it.
- Definitions:
  - outFree = !out_valid || vrfWrite_ready.
  - match = hold_valid && !hold_last && enq key == hold key.
- Flush condition: hold_valid && outFree && (hold_last || timer==TIMEOUT || flush || (enq_valid && !match)). On flush, the hold entry is copied into out and out_valid=1 on the next edge.
- enq_ready = !hold_valid || match || outFree. This is combinational from hold state and vrfWrite_ready.
- Accept (enq_valid && enq_ready):
  - If match: merge. For each byte i with enq mask[i]=1, hold data byte i takes the new byte. hold mask |= enq mask; hold last |= enq last; timer=0.
  - Otherwise: load the new entry into hold, in the same cycle as the flush of the old entry if one was valid; timer=0.
- Timer:
  - Increments each cycle hold_valid && no merge occurs.
  - Saturates at TIMEOUT.
- Out register: cleared on the vrfWrite handshake unless reloaded in the same cycle. A simultaneous handshake and reload is legal and sustains 1 write per cycle.
- Ordering: writes leave in acceptance order; merged writes never reorder across keys.
- Latency:
  - A request with last=1 into an empty block shows vrfWrite_valid 2 cycles after its accept cycle.
  - An isolated request with last=0 shows vrfWrite_valid TIMEOUT+2 cycles after accept.
- Pending counters:
  - +1 for the new entry's index when a request is loaded (not on merge).
  - -1 for the out index on the vrfWrite handshake.
  - Increment and decrement of the same index in one cycle leaves it unchanged.
  - instructionPending[i] = (count[i] != 0); the maximum count is 2.
- Back-pressure: with out full and vrfWrite_ready=0, a matching request is still accepted (merge); a non-matching request is stalled.
- flush with hold empty has no effect.

Decomposition:
- Shared package vrf_write_pkg:
  - vrf_write_req_t struct (vd, offset, mask, data, last, instructionIndex).
  - VD_W=5, OFFSET_W=8, INST_IDX_W=3 constants.
- One sub-module: vrf_pending_counter_bank. It holds the eight saturating up/down counters, takes inc/dec strobes with indices, and drives instructionPending.

Test Plan:
- Merge: vd=3, off=0x10, idx=1, mask 0011, data 0x0000BBAA, then back-to-back mask 1100, data 0xDDCC0000, last=1 → single write mask 1111, data 0xDDCCBBAA, 2 cycles after the second accept. instructionPending[1] stays set until that handshake.
- Overlap: same key, mask 1111 data 0x11223344, then mask 0001 data 0x000000EE, last=1 → data 0x112233EE, mask 1111.
- Key change: vd=2 off=0 then vd=2 off=1, each mask 1111 last=0 → two writes in order, no merge. The second leaves TIMEOUT+2 cycles after its accept.
- Timeout: TIMEOUT=4, single write, no further input → vrfWrite_valid rises exactly 6 cycles after accept; flush=1 instead gives 2 cycles.
- Back-pressure: vrfWrite_ready=0, out and hold full → non-matching request sees enq_ready=0, matching one is merged. Raising ready drains both with no loss, and instructionPending returns to 0.
- Reset mid-operation: hold and out full, reset pulse → next cycle vrfWrite_valid=0, instructionPending=0, enq_ready=1, and no stale write ever appears.
